// File: rtl/pe_pkg.sv
// Shared definitions for the result-memory reader: FSM states and the
// default depth of the 32-bit result memory.
package pe_pkg;

    localparam int MAX_MEM_SIZE_DEF = 128;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LOAD,
        SEND,
        DONE
    } state_t;

endpackage

// File: rtl/unpack4word.sv
// Combinational byte selector: picks one byte out of a 32-bit word.
// Counterpart of register4word; byte 0 is the least significant byte.
module unpack4word (
    input  logic [31:0] word,
    input  logic [1:0]  sel,
    output logic [7:0]  byte_out
);

    // Select byte sel of the word, LSB first.
    always_comb begin
        byte_out = word[7:0];
        case (sel)
            2'd0: byte_out = word[7:0];
            2'd1: byte_out = word[15:8];
            2'd2: byte_out = word[23:16];
            2'd3: byte_out = word[31:24];
            default: byte_out = word[7:0];
        endcase
    end

endmodule

// File: rtl/res_mem_reader.sv
// Result-memory reader: fetches num_words 32-bit words starting at base_adr
// (wrapping modulo the memory depth) and streams them out byte by byte over
// a valid/ready handshake, LSB first, with a running byte index.
module res_mem_reader
    import pe_pkg::*;
#(
    parameter int MAX_MEM_SIZE = MAX_MEM_SIZE_DEF,
    parameter int ADR_W        = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADR_W-1:0]   base_adr,
    input  logic [ADR_W-1:0]   num_words,
    output logic               rd_en,
    output logic [ADR_W-1:0]   rd_adr,
    input  logic [31:0]        rd_data,
    output logic [7:0]         out_byte,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ADR_W+1:0]   out_index,
    output logic               busy,
    output logic               done
);

    // Memory depth at the width of the address sum, for the wrap modulo.
    localparam logic [ADR_W:0] MEM_SIZE = (ADR_W+1)'(MAX_MEM_SIZE);

    state_t             state;
    state_t             state_nxt;

    logic [ADR_W-1:0]   base_q;
    logic [ADR_W-1:0]   num_q;
    logic [ADR_W-1:0]   word_cnt;
    logic [1:0]         byte_cnt;
    logic [31:0]        word_q;

    logic [ADR_W:0]     adr_sum;
    logic [7:0]         sel_byte;
    logic               accept;
    logic               last_byte;
    logic               last_word;

    // The sum is one bit wider than an address so the wrap is exact.
    assign adr_sum   = {1'b0, base_q} + {1'b0, word_cnt};
    assign accept    = (state == SEND) && out_ready;
    assign last_byte = (byte_cnt == 2'd3);
    assign last_word = (word_cnt == num_q - ADR_W'(1));

    unpack4word u_unpack (
        .word     (word_q),
        .sel      (byte_cnt),
        .byte_out (sel_byte)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        rd_adr    = '0;
        out_valid = 1'b0;
        out_byte  = '0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = (num_words == '0) ? DONE : READ;
                end
            end
            READ: begin
                rd_en     = 1'b1;
                rd_adr    = ADR_W'(adr_sum % MEM_SIZE);
                state_nxt = LOAD;
            end
            LOAD: begin
                state_nxt = SEND;
            end
            SEND: begin
                out_valid = 1'b1;
                out_byte  = sel_byte;
                if (accept && last_byte) begin
                    state_nxt = last_word ? DONE : READ;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Transfer bookkeeping: request capture, word fetch and byte counting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_q    <= '0;
            num_q     <= '0;
            word_cnt  <= '0;
            byte_cnt  <= '0;
            word_q    <= '0;
            out_index <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q    <= base_adr;
                        num_q     <= num_words;
                        word_cnt  <= '0;
                        byte_cnt  <= '0;
                        out_index <= '0;
                    end
                end
                LOAD: begin
                    word_q   <= rd_data;
                    byte_cnt <= '0;
                end
                SEND: begin
                    if (accept) begin
                        byte_cnt  <= byte_cnt + 2'd1;
                        out_index <= out_index + (ADR_W+2)'(1);
                        if (last_byte) begin
                            word_cnt <= word_cnt + ADR_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/res_mem_reader.md
RES_MEM_READER -- requirements
Module: res_mem_reader

Interface
REQ-001 Parameter MAX_MEM_SIZE, default 128: depth of the 32-bit result memory being read.
REQ-002 Parameter ADR_W, default 8: width of word addresses and word counts.
REQ-003 Port clk, input, 1: the only clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous and active-low.
REQ-005 Port start, input, 1: single-cycle request to begin a read-out; honoured only in IDLE.
REQ-006 Port base_adr, input, ADR_W: first word address; sampled when start is accepted.
REQ-007 Port num_words, input, ADR_W: number of words to read; sampled when start is accepted.
REQ-008 Port rd_en, output, 1: memory read strobe.
REQ-009 Port rd_adr, output, ADR_W: memory read address.
REQ-010 Port rd_data, input, 32: memory word, valid exactly one cycle after the rd_en cycle.
REQ-011 Port out_byte, output, 8: unpacked result byte.
REQ-012 Port out_valid, output, 1: out_byte and out_index are valid.
REQ-013 Port out_ready, input, 1: consumer accepts the byte when out_valid and out_ready are both high in a cycle.
REQ-014 Port out_index, output, ADR_W+2: byte index within the transfer, starting at 0.
REQ-015 Port busy, output, 1: high in every state except IDLE.
REQ-016 Port done, output, 1: one-cycle pulse after the last byte is accepted.

Function
REQ-017 FSM states: IDLE, READ, LOAD, SEND, DONE.
REQ-018 IDLE->READ on start with num_words!=0; IDLE->DONE on start with num_words==0; otherwise remain in IDLE.
REQ-019 READ: rd_en=1, rd_adr=(base_adr+word_cnt) mod MAX_MEM_SIZE; next state LOAD.
REQ-020 LOAD: capture rd_data into word register, clear byte_cnt; next state SEND.
REQ-021 SEND: out_valid=1, out_byte=word[8*byte_cnt+7 : 8*byte_cnt]; byte 0 (bits 7:0) goes first.
REQ-022 On accept in SEND: byte_cnt and out_index increment; at byte_cnt==3 word_cnt increments and the next state is READ, or DONE if that word was word num_words-1.
REQ-023 While out_valid is high and out_ready is low, out_byte and out_index hold stable and the state does not change.
REQ-024 DONE: done=1 for exactly one cycle; next state IDLE.
REQ-025 start while busy is ignored; base_adr and num_words changing mid-transfer have no effect.
REQ-026 Per-word latency without backpressure is 2 cycles (READ, LOAD) plus 4 SEND cycles; a full transfer takes 6*num_words+1 cycles from the accepted start to the done pulse.
REQ-027 rd_en is high only in READ, and there is exactly one read per word.
REQ-028 Address wrap: rd_adr wraps modulo MAX_MEM_SIZE (e.g. base 126 with 4 words reads 126, 127, 0, 1).
REQ-029 out_index counts 0 .. 4*num_words-1 with no wrap; its width covers 4*(2^ADR_W-1).

Reset
REQ-030 Asserting rst asynchronously forces IDLE, with rd_en=0, out_valid=0, done=0, busy=0, out_byte=0, out_index=0, and word_cnt, byte_cnt and the word register all cleared.
REQ-031 A reset during a transfer abandons it: no done pulse, and the next start begins fresh.

Structure
REQ-032 The state enum and MAX_MEM_SIZE default live in shared package pe_pkg.
REQ-033 Byte selection is the single sub-module unpack4word (32-bit word plus 2-bit index to 8-bit byte, combinational), the counterpart of register4word.

Verification
REQ-034 Memory [0]=0x44332211, [1]=0x88776655; start, base 0, 2 words, out_ready=1 -> bytes 11,22,33,44,55,66,77,88 at out_index 0-7; done 13 cycles after start.
REQ-035 Same memory; out_ready low for 3 cycles while byte 0x33 is presented -> 0x33 and index 2 held stable; no byte lost or duplicated.
REQ-036 start with num_words=0 -> no rd_en; done one cycle later; busy high for exactly 1 cycle.
REQ-037 base 126, 4 words -> rd_adr sequence 126, 127, 0, 1.
REQ-038 rst low during the second word's SEND -> all outputs 0 immediately; a subsequent start with base 0 and 1 word yields 11,22,33,44 and done.
REQ-039 start pulsed again mid-transfer -> ignored; byte count and done timing unchanged.
